// File: rtl/triangle_judge.sv
// Serial 3-sample side-length receiver: collects a burst, sorts it with three
// compare-swap steps, then pulses a registered triangle verdict and class.
module triangle_judge #(
  parameter int unsigned W = 3
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         IN_VALID,
  input  logic [W-1:0] INPUT,
  output logic         OUT,
  output logic         OUT_VALID,
  output logic [1:0]   OUT_KIND
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    S1,
    S2,
    S3,
    CHK,
    RESP,
    WAIT
  } state_t;

  state_t       state;
  logic [1:0]   cnt;
  logic [W-1:0] a, b, c;
  logic         tri_r;
  logic [1:0]   kind_r;

  logic [W:0]   sum_ab;
  logic         is_tri;
  logic [1:0]   kind;

  // Sides are sorted by the time CHK runs, so only the largest side needs testing.
  always_comb begin
    sum_ab = {1'b0, a} + {1'b0, b};
    is_tri = sum_ab > {1'b0, c};
    kind   = 2'd0;
    if (is_tri) begin
      if (a == c)
        kind = 2'd3;
      else if (a == b || b == c)
        kind = 2'd2;
      else
        kind = 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      tri_r     <= 1'b0;
      kind_r    <= '0;
      OUT       <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_KIND  <= '0;
    end else begin
      OUT       <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_KIND  <= '0;
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            a     <= INPUT;
            cnt   <= 2'd1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (IN_VALID) begin
            if (cnt == 2'd1) begin
              b   <= INPUT;
              cnt <= 2'd2;
            end else begin
              c     <= INPUT;
              cnt   <= 2'd3;
              state <= S1;
            end
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        S1: begin
          if (a > b) begin
            a <= b;
            b <= a;
          end
          state <= S2;
        end
        S2: begin
          if (b > c) begin
            b <= c;
            c <= b;
          end
          state <= S3;
        end
        S3: begin
          if (a > b) begin
            a <= b;
            b <= a;
          end
          state <= CHK;
        end
        CHK: begin
          tri_r  <= is_tri;
          kind_r <= kind;
          state  <= RESP;
        end
        RESP: begin
          OUT_VALID <= 1'b1;
          OUT       <= tri_r;
          OUT_KIND  <= kind_r;
          cnt       <= '0;
          // A still-high IN_VALID belongs to the old burst; wait for it to drop.
          state     <= IN_VALID ? WAIT : IDLE;
        end
        WAIT: begin
          if (!IN_VALID)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_judge.sv
// Randomized self-checking bench for triangle_judge with a sort-and-compare reference model.
module tb_triangle_judge;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_data;
  logic       out;
  logic       out_valid;
  logic [1:0] out_kind;

  int tests;
  int fails;
  logic prev_ov;

  triangle_judge #(.W(3)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .IN_VALID  (in_valid),
    .INPUT     (in_data),
    .OUT       (out),
    .OUT_VALID (out_valid),
    .OUT_KIND  (out_kind)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A valid pulse must never last two cycles.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      tests++;
      if (out_valid === 1'b1 && prev_ov === 1'b1) begin
        fails++;
        $display("FAIL pulse_width: out_valid high 2 cycles at %0t, required single cycle", $time);
      end
    end
    prev_ov = out_valid;
  end

  function automatic void ref_judge(input int s0, input int s1, input int s2,
                                    output logic exp_out, output logic [1:0] exp_kind);
    int v[3];
    int t;
    int eq;
    v[0] = s0; v[1] = s1; v[2] = s2;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    exp_out = (v[0] + v[1] > v[2]);
    eq = int'(s0 == s1) + int'(s1 == s2) + int'(s0 == s2);
    if (!exp_out)     exp_kind = 2'd0;
    else if (eq == 3) exp_kind = 2'd3;
    else if (eq == 1) exp_kind = 2'd2;
    else              exp_kind = 2'd1;
  endfunction

  // Drives three sides then `extra` ignored samples; watches a 16-cycle window
  // in which the only pulse must appear exactly 5 edges after the 3rd sample.
  task automatic drive_and_check(input int s0, input int s1, input int s2,
                                 input int extra, input string name);
    logic       exp_out;
    logic [1:0] exp_kind;
    int         sides[3];
    ref_judge(s0, s1, s2, exp_out, exp_kind);
    sides[0] = s0; sides[1] = s1; sides[2] = s2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 3'(sides[k]);
    end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== (i == 6)) begin
        fails++;
        $display("FAIL %s out_valid cycle %0d: got %b, required %b", name, i, out_valid, (i == 6));
      end
      if (i == 6) begin
        tests++;
        if (out !== exp_out || out_kind !== exp_kind) begin
          fails++;
          $display("FAIL %s verdict (%0d,%0d,%0d): got out=%b kind=%0d, required out=%b kind=%0d",
                   name, s0, s1, s2, out, out_kind, exp_out, exp_kind);
        end
      end else begin
        tests++;
        if (out !== 1'b0 || out_kind !== 2'd0) begin
          fails++;
          $display("FAIL %s idle outputs cycle %0d: got out=%b kind=%0d, required 0/0",
                   name, i, out, out_kind);
        end
      end
      in_valid = (i <= extra);
      in_data  = 3'($urandom_range(0, 7));
    end
    in_valid = 1'b0;
  endtask

  task automatic watch_silent(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || out !== 1'b0 || out_kind !== 2'd0) begin
        fails++;
        $display("FAIL %s silent cycle %0d: got valid=%b out=%b kind=%0d, required 0/0/0",
                 name, i, out_valid, out, out_kind);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out !== 1'b0 || out_kind !== 2'd0) begin
      fails++;
      $display("FAIL reset_state: got valid=%b out=%b kind=%0d, required 0/0/0", out_valid, out, out_kind);
    end
    rst_n = 1'b1;
    // Abort a burst after two sides with an asynchronous mid-cycle reset.
    @(negedge clk); in_valid = 1'b1; in_data = 3'd3;
    @(negedge clk); in_data = 3'd4;
    @(posedge clk); #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out !== 1'b0 || out_kind !== 2'd0) begin
      fails++;
      $display("FAIL reset_async: got valid=%b out=%b kind=%0d, required 0/0/0", out_valid, out, out_kind);
    end
    @(negedge clk); rst_n = 1'b1;
    watch_silent(12, "reset_release");
  endtask

  task automatic test_equilateral();
    drive_and_check(7, 7, 7, 0, "equilateral_777");
  endtask

  task automatic test_degenerate();
    drive_and_check(1, 2, 1, 0, "degenerate_121");
    drive_and_check(3, 1, 1, 0, "impossible_311");
  endtask

  task automatic test_kinds();
    drive_and_check(3, 4, 6, 0, "scalene_346");
    drive_and_check(2, 3, 2, 0, "isosceles_232");
    drive_and_check(0, 0, 0, 0, "zero_000");
    drive_and_check(7, 7, 6, 0, "overflow_776");
  endtask

  task automatic test_short_burst();
    @(negedge clk); in_valid = 1'b1; in_data = 3'd5;
    @(negedge clk); in_data = 3'd5;
    @(negedge clk); in_valid = 1'b0;
    watch_silent(10, "short_burst");
    drive_and_check(4, 5, 6, 0, "after_short_456");
  endtask

  task automatic test_long_burst();
    drive_and_check(6, 6, 6, 2, "long_burst_66611");
    drive_and_check(6, 6, 6, 8, "long_burst_through_resp");
    drive_and_check(5, 3, 4, 0, "after_long_534");
  endtask

  task automatic test_back_to_back();
    drive_and_check(2, 2, 3, 0, "b2b_first");
    drive_and_check(1, 7, 7, 0, "b2b_second");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      drive_and_check(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 9)), "random");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    prev_ov = 1'b0;
    test_reset();
    test_equilateral();
    test_degenerate();
    test_kinds();
    test_short_burst();
    test_long_burst();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
